accel_seq: RTL

Sequencer between the AXI-lite control register block and the accelerator datapath. It decodes the 2-bit command state from the control block and moves DMA AXI-stream beats into the parameter buffer or the image buffer. It can also start the compute engine and wait for it to finish. When the operation completes it returns a one-cycle `o_state_cnvt` pulse, which sends the control block back to IDLE.

---
 rtl/accel_pkg.sv | 31 +++
 rtl/accel_seq_beat_counter.sv | 39 +++
 rtl/accel_seq.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/accel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : accel_pkg
//  Description : Shared encodings for the accelerator sequencer. Command
//                codes match the control register block; sequencer state
//                codes are used by accel_seq.
//  Revision    : 1.0  initial release
// ============================================================================
package accel_pkg;

    // Command codes driven by the control block on i_state
    localparam logic [1:0] c_CMD_IDLE        = 2'd0;
    localparam logic [1:0] c_CMD_PARAM_LOAD  = 2'd1;
    localparam logic [1:0] c_CMD_IMAGE_LOAD  = 2'd2;
    localparam logic [1:0] c_CMD_START_ACCEL = 2'd3;

    // Sequencer state codes
    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_PARAM = 3'd1;
    localparam logic [2:0] c_S_IMAGE = 3'd2;
    localparam logic [2:0] c_S_RUN   = 3'd3;
    localparam logic [2:0] c_S_DONE  = 3'd4;
    localparam logic [2:0] c_S_WAIT  = 3'd5;

    // True for the two states that accept stream beats
    function automatic logic is_load_state(input logic [2:0] state);
        return (state == c_S_PARAM) || (state == c_S_IMAGE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/accel_seq_beat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : beat_counter
//  Description : Stream beat counter with synchronous clear, increment
//                enable and a compare against a runtime terminal value.
//  Revision    : 1.0  initial release
// ============================================================================
module beat_counter
    import accel_pkg::*;
#(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_term,
    output logic [WIDTH-1:0] o_count,
    output logic             o_at_term
);

    logic [WIDTH-1:0] r_count;

    // Clear wins over increment so an abort coinciding with a beat restarts at 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count   = r_count;
    assign o_at_term = (r_count == i_term);

endmodule
`default_nettype wire

// File: rtl/accel_seq.sv
`default_nettype none
// ============================================================================
//  Module      : accel_seq
//  Description : Command sequencer between the AXI-lite control block and
//                the accelerator datapath. Streams DMA beats into the
//                parameter or image buffer, or starts the compute engine and
//                waits for it, then returns a one-cycle completion pulse.
//                Optional feature macro: ACCEL_SEQ_TLAST_CHK_EN adds a sticky
//                o_tlast_err flag for tlast/beat-count disagreement.
//  Revision    : 1.0  initial release
// ============================================================================
module accel_seq
    import accel_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int PARAM_WORDS = 256,
    parameter int IMAGE_WORDS = 1024,
    parameter int ADDR_W      = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        i_state,
    output logic              o_state_cnvt,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic              o_pbuf_we,
    output logic [ADDR_W-1:0] o_pbuf_addr,
    output logic              o_ibuf_we,
    output logic [ADDR_W-1:0] o_ibuf_addr,
    output logic [DATA_W-1:0] o_buf_wdata,
    output logic              o_eng_start,
    input  logic              i_eng_done,
    output logic              o_busy
`ifdef ACCEL_SEQ_TLAST_CHK_EN
    ,
    output logic              o_tlast_err
`endif
);

    // Terminal counter values; counter is one bit wider than the address
    localparam logic [ADDR_W:0] c_PARAM_TERM = (ADDR_W+1)'(PARAM_WORDS - 1);
    localparam logic [ADDR_W:0] c_IMAGE_TERM = (ADDR_W+1)'(IMAGE_WORDS - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic              w_tready;
    logic              w_hs;
    logic              w_cnt_clr;
    logic              w_load_entry;
    logic              w_start;
    logic [ADDR_W:0]   w_term;
    logic [ADDR_W:0]   w_count;
    logic              w_at_term;

    logic              r_pbuf_we;
    logic              r_ibuf_we;
    logic [ADDR_W-1:0] r_pbuf_addr;
    logic [ADDR_W-1:0] r_ibuf_addr;
    logic [DATA_W-1:0] r_buf_wdata;
    logic              r_eng_start;
    logic              r_state_cnvt;

    // Only the low ADDR_W bits address the buffers; the MSB exists for the compare
    logic              w_unused_cnt_msb;
    assign w_unused_cnt_msb = w_count[ADDR_W];

    // Ready depends on state alone so tvalid never combinationally loops back
    assign w_tready = is_load_state(r_state);
    assign w_hs     = s_axis_tvalid & w_tready;
    assign w_term   = (r_state == c_S_IMAGE) ? c_IMAGE_TERM : c_PARAM_TERM;

    // Next-state decode, counter clear and engine start request
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_clr    = 1'b0;
        w_load_entry = 1'b0;
        w_start      = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                case (i_state)
                    c_CMD_PARAM_LOAD: begin
                        w_state_nxt  = c_S_PARAM;
                        w_cnt_clr    = 1'b1;
                        w_load_entry = 1'b1;
                    end
                    c_CMD_IMAGE_LOAD: begin
                        w_state_nxt  = c_S_IMAGE;
                        w_cnt_clr    = 1'b1;
                        w_load_entry = 1'b1;
                    end
                    c_CMD_START_ACCEL: begin
                        w_state_nxt = c_S_RUN;
                        w_start     = 1'b1;
                    end
                    default: w_state_nxt = c_S_IDLE;
                endcase
            end
            c_S_PARAM, c_S_IMAGE: begin
                if (i_state == c_CMD_IDLE) begin
                    w_state_nxt = c_S_IDLE;
                    w_cnt_clr   = 1'b1;
                end else if (w_hs && w_at_term) begin
                    w_state_nxt = c_S_DONE;
                end
            end
            c_S_RUN: begin
                // Done seen alongside the start pulse belongs to a previous run
                if (i_state == c_CMD_IDLE) begin
                    w_state_nxt = c_S_IDLE;
                    w_cnt_clr   = 1'b1;
                end else if (i_eng_done && !r_eng_start) begin
                    w_state_nxt = c_S_DONE;
                end
            end
            c_S_DONE: begin
                w_state_nxt = c_S_WAIT;
            end
            c_S_WAIT: begin
                // Hold off the stale command until the control block returns to idle
                if (i_state == c_CMD_IDLE) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    beat_counter #(
        .WIDTH (ADDR_W + 1)
    ) u_beat_counter (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_cnt_clr),
        .i_en      (w_hs),
        .i_term    (w_term),
        .o_count   (w_count),
        .o_at_term (w_at_term)
    );

    // Buffer write port: capture each accepted beat and pulse the matching enable
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pbuf_we   <= 1'b0;
            r_ibuf_we   <= 1'b0;
            r_pbuf_addr <= '0;
            r_ibuf_addr <= '0;
            r_buf_wdata <= '0;
        end else begin
            r_pbuf_we <= w_hs && (r_state == c_S_PARAM);
            r_ibuf_we <= w_hs && (r_state == c_S_IMAGE);
            if (w_hs) begin
                r_buf_wdata <= s_axis_tdata;
            end
            if (w_hs && (r_state == c_S_PARAM)) begin
                r_pbuf_addr <= w_count[ADDR_W-1:0];
            end
            if (w_hs && (r_state == c_S_IMAGE)) begin
                r_ibuf_addr <= w_count[ADDR_W-1:0];
            end
        end
    end

    // Engine start and completion pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_eng_start  <= 1'b0;
            r_state_cnvt <= 1'b0;
        end else begin
            r_eng_start  <= w_start;
            r_state_cnvt <= (r_state == c_S_DONE);
        end
    end

`ifdef ACCEL_SEQ_TLAST_CHK_EN
    logic r_tlast_err;

    // Sticky flag: tlast must be high exactly on the terminal beat
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tlast_err <= 1'b0;
        end else if (w_load_entry) begin
            r_tlast_err <= 1'b0;
        end else if (w_hs && (s_axis_tlast != w_at_term)) begin
            r_tlast_err <= 1'b1;
        end
    end

    assign o_tlast_err = r_tlast_err;
`else
    logic w_unused_tlast;
    logic w_unused_entry;
    assign w_unused_tlast = s_axis_tlast;
    assign w_unused_entry = w_load_entry;
`endif

    assign s_axis_tready = w_tready;
    assign o_busy        = (r_state != c_S_IDLE);
    assign o_pbuf_we     = r_pbuf_we;
    assign o_ibuf_we     = r_ibuf_we;
    assign o_pbuf_addr   = r_pbuf_addr;
    assign o_ibuf_addr   = r_ibuf_addr;
    assign o_buf_wdata   = r_buf_wdata;
    assign o_eng_start   = r_eng_start;
    assign o_state_cnvt  = r_state_cnvt;

endmodule
`default_nettype wire
